// File: rtl/branch_predictor_if.sv
// Fetch/EX-side signal bundle of the dynamic branch predictor.
// The pipeline drives through master; the predictor sits on slave.
interface branch_predictor_if;
  logic        pred_en;
  logic [31:0] pc_IF;
  logic        pre_br;
  logic [31:0] pre_pc;
  logic        upd_en;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        flush_b;
  logic [31:0] br_total;
  logic [31:0] br_miss;

  modport master (
    output pred_en, pc_IF, upd_en, upd_taken, upd_pc, upd_target, flush_b,
    input  pre_br, pre_pc, br_total, br_miss
  );

  modport slave (
    input  pred_en, pc_IF, upd_en, upd_taken, upd_pc, upd_target, flush_b,
    output pre_br, pre_pc, br_total, br_miss
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tag/target per entry,
// trained by EX-stage resolution, plus branch/misprediction performance counters.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  branch_predictor_if.slave bp
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_r;
  logic [1:0]       cnt_r [DEPTH];
  logic [TAG_W-1:0] tag_r [DEPTH];
  logic [31:0]      tgt_r [DEPTH];
  logic [31:0]      br_total_r;
  logic [31:0]      br_miss_r;

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s;
  logic             pre_br_s;
  logic [31:0]      pre_pc_s;
  logic [IDX_W-1:0] uidx_s;
  logic [TAG_W-1:0] utag_s;
  logic             uhit_s;
  logic             unused_s;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Zero-latency lookup; reads pre-update table contents (no bypass).
  always_comb begin
    idx_s    = bp.pc_IF[IDX_W+1:2];
    tag_s    = bp.pc_IF[31:IDX_W+2];
    hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    pre_br_s = bp.pred_en && hit_s && cnt_r[idx_s][1];
    if (pre_br_s) begin
      pre_pc_s = tgt_r[idx_s];
    end else begin
      pre_pc_s = bp.pc_IF + 32'd4;
    end
  end

  // Training-side index/tag match for the resolved branch.
  always_comb begin
    uidx_s = bp.upd_pc[IDX_W+1:2];
    utag_s = bp.upd_pc[31:IDX_W+2];
    uhit_s = valid_r[uidx_s] && (tag_r[uidx_s] == utag_s);
  end

  assign unused_s  = ^{bp.pc_IF[1:0], bp.upd_pc[1:0]};
  assign bp.pre_br = pre_br_s;
  assign bp.pre_pc = pre_pc_s;

  // Table training: hits move the counter, taken misses allocate at weakly-taken.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= 2'b01;
        tag_r[i] <= {TAG_W{1'b0}};
        tgt_r[i] <= 32'd0;
      end
    end else if (bp.upd_en) begin
      if (uhit_s) begin
        if (bp.upd_taken) begin
          cnt_r[uidx_s] <= sat_inc(cnt_r[uidx_s]);
          tgt_r[uidx_s] <= bp.upd_target;
        end else begin
          cnt_r[uidx_s] <= sat_dec(cnt_r[uidx_s]);
        end
      end else if (bp.upd_taken) begin
        valid_r[uidx_s] <= 1'b1;
        tag_r[uidx_s]   <= utag_s;
        tgt_r[uidx_s]   <= bp.upd_target;
        cnt_r[uidx_s]   <= 2'b10;
      end
    end
  end

  // Performance counters; flush_b only counts alongside a resolved branch.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      br_total_r <= 32'd0;
      br_miss_r  <= 32'd0;
    end else if (bp.upd_en) begin
      br_total_r <= br_total_r + 32'd1;
      if (bp.flush_b) begin
        br_miss_r <= br_miss_r + 32'd1;
      end
    end
  end

  assign bp.br_total = br_total_r;
  assign bp.br_miss  = br_miss_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against an
// entry-level reference model of the predictor table and counters.
module tb_branch_predictor;

  logic cpu_clk = 1'b0;
  logic cpu_rst_n;

  branch_predictor_if bif ();

  branch_predictor #(.IDX_W(6)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .bp       (bif)
  );

  always #5 cpu_clk = ~cpu_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: 64 entries, strength 0..3, taken when strength >= 2
  bit          m_v   [64];
  int          m_cnt [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [31:0] m_total;
  logic [31:0] m_miss;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / 32'd256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0; m_cnt[i] = 1; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
    end
    m_total = 32'd0;
    m_miss  = 32'd0;
  endtask

  task automatic model_update(input logic taken, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic fl);
    int  i;
    bit  hit;
    i   = m_idx(pc);
    hit = m_v[i] && (m_tag[i] == m_tagof(pc));
    if (hit && taken) begin
      m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      m_tgt[i] = tgt;
    end else if (hit) begin
      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end else if (taken) begin
      m_v[i] = 1'b1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_cnt[i] = 2;
    end
    m_total = m_total + 32'd1;
    if (fl) m_miss = m_miss + 32'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Entered at a falling edge: drive, check lookup, let the rising edge train, check counters.
  task automatic cycle(input logic pe, input logic [31:0] pc, input logic ue,
                       input logic ut, input logic [31:0] up, input logic [31:0] tgt,
                       input logic fl);
    int          i;
    logic        exp_br;
    logic [31:0] exp_pc;
    bif.pred_en = pe; bif.pc_IF = pc; bif.upd_en = ue; bif.upd_taken = ut;
    bif.upd_pc = up; bif.upd_target = tgt; bif.flush_b = fl;
    #1;
    i      = m_idx(pc);
    exp_br = pe && m_v[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= 2);
    exp_pc = exp_br ? m_tgt[i] : pc + 32'd4;
    chk("pre_br", {31'd0, bif.pre_br}, {31'd0, exp_br});
    chk("pre_pc", bif.pre_pc, exp_pc);
    @(posedge cpu_clk);
    if (cpu_rst_n && ue) model_update(ut, up, tgt, fl);
    @(negedge cpu_clk);
    chk("br_total", bif.br_total, m_total);
    chk("br_miss", bif.br_miss, m_miss);
  endtask

  initial begin
    logic [31:0] rpc, rup;
    model_reset();
    cpu_rst_n = 1'b0;
    bif.pred_en = 1'b1; bif.pc_IF = 32'h100; bif.upd_en = 1'b0; bif.upd_taken = 1'b0;
    bif.upd_pc = 32'h0; bif.upd_target = 32'h0; bif.flush_b = 1'b0;
    #1;
    chk("rst_pre_br", {31'd0, bif.pre_br}, 32'd0);
    chk("rst_pre_pc", bif.pre_pc, 32'h104);
    chk("rst_total", bif.br_total, 32'd0);
    chk("rst_miss", bif.br_miss, 32'd0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // First taken update at 0x100 while looking up 0x100: no bypass
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("train_taken", {31'd0, bif.pre_br}, 32'd1);
    chk("train_target", bif.pre_pc, 32'h80);
    // Two not-taken: 10 -> 01 -> 00
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("weak_nt_pc", bif.pre_pc, 32'h104);
    // Four taken saturate at 11; one not-taken still predicts taken
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("sat_taken", {31'd0, bif.pre_br}, 32'd1);
    // pred_en=0 masks the prediction
    cycle(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Alias at idx 0 with a different tag, then replacement
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("alias_miss", {31'd0, bif.pre_br}, 32'd0);
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("alias_hit_pc", bif.pre_pc, 32'h300);
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("replaced_miss", {31'd0, bif.pre_br}, 32'd0);
    // Not-taken miss never allocates
    cycle(1'b1, 32'h404, 1'b1, 1'b0, 32'h404, 32'h500, 1'b0);
    cycle(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Counter scenario from a fresh reset
    cpu_rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'h40, 1'b1);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'h40, 1'b0);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h44, 1'b0);
    chk("cnt_total5", bif.br_total, 32'd5);
    chk("cnt_miss2", bif.br_miss, 32'd2);
    chk("pre_rst_taken", {31'd0, bif.pre_br}, 32'd1);
    // Mid-sequence async reset, no clock edge in between
    #2;
    cpu_rst_n = 1'b0;
    #1;
    chk("arst_total", bif.br_total, 32'd0);
    chk("arst_miss", bif.br_miss, 32'd0);
    chk("arst_pre_br", {31'd0, bif.pre_br}, 32'd0);
    model_reset();
    @(negedge cpu_clk);
    // Updates during reset must not land
    cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h44, 1'b1);
    cpu_rst_n = 1'b1;
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Random traffic over a small PC pool so hits, aliases and same-cycle collisions occur
    for (int n = 0; n < 400; n++) begin
      rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      rup = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      cycle(1'($urandom_range(0, 7) != 0), rpc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rup, $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
